// File: rtl/pos_pkg.sv
// rtl/pos_pkg.sv - shared types, status bit indices and helpers for pos_tracker
package pos_pkg;

  typedef enum logic [1:0] {STEP_NONE, STEP_INC, STEP_DEC, STEP_ERR} step_t;
  typedef enum logic [1:0] {S00 = 2'b00, S01 = 2'b01, S11 = 2'b11, S10 = 2'b10} gray_t;

  localparam int ST_XMOV    = 0;
  localparam int ST_YMOV    = 1;
  localparam int ST_XERR    = 2;
  localparam int ST_YERR    = 3;
  localparam int ST_XLIM    = 4;
  localparam int ST_YLIM    = 5;
  localparam int ST_RCNT_LO = 6;
  localparam int ST_RCNT_HI = 7;

  function automatic logic at_limit(input logic [7:0] v);
    return (v == 8'h00) || (v == 8'hFF);
  endfunction

  // A saturated INC/DEC leaves the value unchanged but still counts as a step.
  function automatic logic [7:0] step_pos(input logic [7:0] v, input step_t s, input bit sat);
    logic [7:0] r;
    r = v;
    if (s == STEP_INC && !(sat && v == 8'hFF)) r = v + 8'd1;
    else if (s == STEP_DEC && !(sat && v == 8'h00)) r = v - 8'd1;
    return r;
  endfunction

endpackage

// File: rtl/pos_tracker_if.sv
// rtl/pos_tracker_if.sv - quadrature pins, control and snapshot bytes of pos_tracker
interface pos_tracker_if;
  logic       x_a;
  logic       x_b;
  logic       y_a;
  logic       y_b;
  logic       hold;
  logic       clear;
  logic [7:0] x_pos;
  logic [7:0] y_pos;
  logic [7:0] status;

  modport master (output x_a, x_b, y_a, y_b, hold, clear,
                  input  x_pos, y_pos, status);
  modport slave  (input  x_a, x_b, y_a, y_b, hold, clear,
                  output x_pos, y_pos, status);
endinterface

// File: rtl/pos_tracker_quad_decoder.sv
// rtl/pos_tracker_quad_decoder.sv - per-axis synchronizer, priming counter and Gray step decoder
module quad_decoder
  import pos_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  a_i,
  input  logic  b_i,
  output step_t step_o
);

  logic [SYNC_STAGES-1:0] a_sync_q;
  logic [SYNC_STAGES-1:0] b_sync_q;
  logic [2:0]             prime_cnt_q;
  logic                   primed_q;
  gray_t                  state_q;
  gray_t                  sample;

  assign sample = gray_t'({a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]});

  always_comb begin
    step_o = STEP_NONE;
    if (primed_q && sample != state_q) begin
      step_o = STEP_ERR;
      case (state_q)
        S00: if (sample == S01) step_o = STEP_INC; else if (sample == S10) step_o = STEP_DEC;
        S01: if (sample == S11) step_o = STEP_INC; else if (sample == S00) step_o = STEP_DEC;
        S11: if (sample == S10) step_o = STEP_INC; else if (sample == S01) step_o = STEP_DEC;
        S10: if (sample == S00) step_o = STEP_INC; else if (sample == S11) step_o = STEP_DEC;
        default: step_o = STEP_ERR;
      endcase
    end
  end

  // Until the chain holds real pin samples, the first one is adopted silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync_q    <= '0;
      b_sync_q    <= '0;
      prime_cnt_q <= '0;
      primed_q    <= 1'b0;
      state_q     <= S00;
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], a_i};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], b_i};
      if (!primed_q) begin
        if (prime_cnt_q == 3'(SYNC_STAGES)) begin
          primed_q <= 1'b1;
          state_q  <= sample;
        end else begin
          prime_cnt_q <= prime_cnt_q + 3'd1;
        end
      end else begin
        state_q <= sample;
      end
    end
  end

endmodule

// File: rtl/pos_tracker.sv
// rtl/pos_tracker.sv - two-axis quadrature position tracker with sticky flags and freezable snapshot
module pos_tracker
  import pos_pkg::*;
#(
  parameter bit         SATURATE    = 1'b1,
  parameter logic [7:0] X_INIT      = 8'd128,
  parameter logic [7:0] Y_INIT      = 8'd128,
  parameter int         SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          rst_n,
  pos_tracker_if.slave bus
);

  localparam logic [7:0] STATUS_RST = {2'b00, at_limit(Y_INIT), at_limit(X_INIT), 4'b0000};

  step_t      x_step;
  step_t      y_step;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [3:0] flags_q, flags_d;
  logic [1:0] rcnt_q, rcnt_d;
  logic [7:0] live_status;
  logic [7:0] x_pos_q, y_pos_q, status_q;

  quad_decoder #(.SYNC_STAGES(SYNC_STAGES)) u_x_dec (
    .clk   (clk),
    .rst_n (rst_n),
    .a_i   (bus.x_a),
    .b_i   (bus.x_b),
    .step_o(x_step)
  );

  quad_decoder #(.SYNC_STAGES(SYNC_STAGES)) u_y_dec (
    .clk   (clk),
    .rst_n (rst_n),
    .a_i   (bus.y_a),
    .b_i   (bus.y_b),
    .step_o(y_step)
  );

  // Clear is applied first so a same-cycle set event survives it.
  always_comb begin
    x_d     = step_pos(x_q, x_step, SATURATE);
    y_d     = step_pos(y_q, y_step, SATURATE);
    flags_d = bus.clear ? 4'b0000 : flags_q;
    if (x_step == STEP_INC || x_step == STEP_DEC) flags_d[ST_XMOV] = 1'b1;
    if (y_step == STEP_INC || y_step == STEP_DEC) flags_d[ST_YMOV] = 1'b1;
    if (x_step == STEP_ERR) flags_d[ST_XERR] = 1'b1;
    if (y_step == STEP_ERR) flags_d[ST_YERR] = 1'b1;
    rcnt_d  = rcnt_q + {1'b0, bus.clear};
  end

  assign live_status = {rcnt_q, at_limit(y_q), at_limit(x_q), flags_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= X_INIT;
      y_q      <= Y_INIT;
      flags_q  <= '0;
      rcnt_q   <= '0;
      x_pos_q  <= X_INIT;
      y_pos_q  <= Y_INIT;
      status_q <= STATUS_RST;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      flags_q <= flags_d;
      rcnt_q  <= rcnt_d;
      if (!bus.hold) begin
        x_pos_q  <= x_q;
        y_pos_q  <= y_q;
        status_q <= live_status;
      end
    end
  end

  assign bus.x_pos  = x_pos_q;
  assign bus.y_pos  = y_pos_q;
  assign bus.status = status_q;

endmodule

// File: tb/tb_pos_tracker.sv
// tb/tb_pos_tracker.sv - randomized self-checking bench for pos_tracker against a Gray-index position model
module tb_pos_tracker;
  import pos_pkg::*;

  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] px = 2'b11;
  logic [1:0] py = 2'b11;
  logic       hold_r = 1'b0;
  logic       clear_r = 1'b0;

  always #5 clk = ~clk;

  pos_tracker_if bus0();
  pos_tracker_if bus1();
  pos_tracker_if bus2();

  assign {bus0.x_a, bus0.x_b, bus0.y_a, bus0.y_b, bus0.hold, bus0.clear} = {px, py, hold_r, clear_r};
  assign {bus1.x_a, bus1.x_b, bus1.y_a, bus1.y_b, bus1.hold, bus1.clear} = {px, py, hold_r, clear_r};
  assign {bus2.x_a, bus2.x_b, bus2.y_a, bus2.y_b, bus2.hold, bus2.clear} = {px, py, hold_r, clear_r};

  pos_tracker #(.SATURATE(1'b1), .X_INIT(8'd128), .Y_INIT(8'd128), .SYNC_STAGES(SS))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  pos_tracker #(.SATURATE(1'b1), .X_INIT(8'd254), .Y_INIT(8'd128), .SYNC_STAGES(SS))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  pos_tracker #(.SATURATE(1'b0), .X_INIT(8'd254), .Y_INIT(8'd128), .SYNC_STAGES(SS))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic [7:0] xo[3], yo[3], so[3];
  assign xo[0] = bus0.x_pos;  assign yo[0] = bus0.y_pos;  assign so[0] = bus0.status;
  assign xo[1] = bus1.x_pos;  assign yo[1] = bus1.y_pos;  assign so[1] = bus1.status;
  assign xo[2] = bus2.x_pos;  assign yo[2] = bus2.y_pos;  assign so[2] = bus2.status;

  int         m_sat[3]  = '{1, 1, 0};
  int         m_xini[3] = '{128, 254, 254};
  int         mx[3], my[3];
  logic [3:0] mflags[3];
  logic [1:0] mrcnt[3];
  int         n_checks = 0;
  int         n_pass = 0;

  function automatic int gray_idx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gray_code(input int idx);
    case (idx)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic int move(input int p, input int dir, input int sat);
    int r;
    r = p + dir;
    if (sat != 0) begin
      if (r > 255) r = 255;
      if (r < 0) r = 0;
    end else begin
      r = (r + 256) % 256;
    end
    return r;
  endfunction

  function automatic logic lim(input int v);
    return (v == 0) || (v == 255);
  endfunction

  function automatic logic [7:0] exp_status(input int i);
    return {mrcnt[i], lim(my[i]), lim(mx[i]), mflags[i]};
  endfunction

  task automatic model_axis(input int axis, input logic [1:0] from, input logic [1:0] to);
    int d;
    d = (gray_idx(to) - gray_idx(from) + 4) % 4;
    for (int i = 0; i < 3; i++) begin
      if (d == 1 || d == 3) begin
        if (axis == 0) mx[i] = move(mx[i], (d == 1) ? 1 : -1, m_sat[i]);
        else           my[i] = move(my[i], (d == 1) ? 1 : -1, m_sat[i]);
        mflags[i][axis] = 1'b1;
      end else if (d == 2) begin
        mflags[i][2 + axis] = 1'b1;
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      mflags[i] = 4'b0000;
      mrcnt[i]  = mrcnt[i] + 2'd1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mx[i] = m_xini[i];
      my[i] = 128;
      mflags[i] = 4'b0000;
      mrcnt[i]  = 2'd0;
    end
  endtask

  task automatic set_pins(input logic [1:0] nx, input logic [1:0] ny, input bit upd);
    if (upd) begin
      model_axis(0, px, nx);
      model_axis(1, py, ny);
    end
    px = nx;
    py = ny;
  endtask

  task automatic step_x(input int dir);
    set_pins(gray_code((gray_idx(px) + dir + 4) % 4), py, 1'b1);
  endtask

  task automatic pulse_clear();
    clear_r = 1'b1;
    model_clear();
    @(negedge clk);
    clear_r = 1'b0;
  endtask

  task automatic do_reset(input logic [1:0] ix, input logic [1:0] iy);
    @(negedge clk);
    #2;
    rst_n   = 1'b0;
    hold_r  = 1'b0;
    clear_r = 1'b0;
    px = ix;
    py = iy;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset(2'b11, 2'b11);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (xo[i] !== 8'(mx[i]) || yo[i] !== 8'(my[i]) || so[i] !== exp_status(i))
        $display("FAIL reset dut%0d: got x=%h y=%h st=%h want x=%h y=%h st=%h",
                 i, xo[i], yo[i], so[i], 8'(mx[i]), 8'(my[i]), exp_status(i));
      else n_pass++;
    end
    n_checks++;
    if (xo[0] !== 8'h80 || yo[0] !== 8'h80 || so[0] !== 8'h00)
      $display("FAIL reset_const: got x=%h y=%h st=%h want 80 80 00", xo[0], yo[0], so[0]);
    else n_pass++;
  endtask

  task automatic test_forward();
    logic [7:0] old;
    do_reset(2'b11, 2'b11);
    for (int s = 0; s < 5; s++) begin
      old = 8'(mx[0]);
      step_x(1);
      repeat (SS + 1) @(negedge clk);
      n_checks++;
      if (xo[0] !== old) $display("FAIL fwd_early step%0d: got %h want %h", s, xo[0], old);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (xo[0] !== 8'(mx[0])) $display("FAIL fwd_latency step%0d: got %h want %h", s, xo[0], 8'(mx[0]));
      else n_pass++;
    end
    n_checks++;
    if (xo[0] !== 8'h85 || so[0] !== 8'h01)
      $display("FAIL fwd_final: got x=%h st=%h want 85 01", xo[0], so[0]);
    else n_pass++;
    for (int i = 1; i < 3; i++) begin
      n_checks++;
      if (xo[i] !== 8'(mx[i]) || so[i] !== exp_status(i))
        $display("FAIL fwd dut%0d: got x=%h st=%h want x=%h st=%h", i, xo[i], so[i], 8'(mx[i]), exp_status(i));
      else n_pass++;
    end
  endtask

  task automatic test_saturate();
    do_reset(2'b11, 2'b11);
    repeat (3) begin
      step_x(1);
      repeat (SS + 2) @(negedge clk);
    end
    n_checks++;
    if (xo[1] !== 8'hFF || so[1][ST_XLIM] !== 1'b1)
      $display("FAIL sat: got x=%h st=%h want x=ff bit4=1", xo[1], so[1]);
    else n_pass++;
    n_checks++;
    if (xo[2] !== 8'h01 || so[2][ST_XLIM] !== 1'b0)
      $display("FAIL wrap: got x=%h st=%h want x=01 bit4=0", xo[2], so[2]);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (xo[i] !== 8'(mx[i]) || so[i] !== exp_status(i))
        $display("FAIL satwrap dut%0d: got x=%h st=%h want x=%h st=%h", i, xo[i], so[i], 8'(mx[i]), exp_status(i));
      else n_pass++;
    end
  endtask

  task automatic test_illegal_clear();
    do_reset(2'b00, 2'b00);
    set_pins(px, 2'b11, 1'b1);
    repeat (SS + 2) @(negedge clk);
    n_checks++;
    if (so[0] !== 8'h08 || yo[0] !== 8'h80)
      $display("FAIL illegal: got st=%h y=%h want 08 80", so[0], yo[0]);
    else n_pass++;
    pulse_clear();
    repeat (SS + 2) @(negedge clk);
    n_checks++;
    if (so[0] !== 8'h40) $display("FAIL illegal_clear: got st=%h want 40", so[0]);
    else n_pass++;
    for (int i = 1; i < 3; i++) begin
      n_checks++;
      if (so[i] !== exp_status(i)) $display("FAIL illegal dut%0d: got st=%h want %h", i, so[i], exp_status(i));
      else n_pass++;
    end
  endtask

  task automatic test_hold();
    logic [7:0] frozen;
    do_reset(2'b11, 2'b11);
    hold_r = 1'b1;
    frozen = 8'(mx[0]);
    repeat (3) begin
      step_x(-1);
      repeat (SS + 2) @(negedge clk);
      n_checks++;
      if (xo[0] !== frozen) $display("FAIL hold_frozen: got %h want %h", xo[0], frozen);
      else n_pass++;
    end
    hold_r = 1'b0;
    @(negedge clk);
    n_checks++;
    if (xo[0] !== 8'h7D || xo[0] !== 8'(mx[0]) || so[0] !== exp_status(0))
      $display("FAIL hold_release: got x=%h st=%h want x=7d st=%h", xo[0], so[0], exp_status(0));
    else n_pass++;
  endtask

  task automatic test_clear_collision();
    do_reset(2'b11, 2'b11);
    set_pins(px, 2'b01, 1'b0);
    repeat (SS) @(negedge clk);
    clear_r = 1'b1;
    model_clear();
    model_axis(1, 2'b11, 2'b01);
    @(negedge clk);
    clear_r = 1'b0;
    repeat (SS + 2) @(negedge clk);
    n_checks++;
    if (so[0] !== 8'h42 || yo[0] !== 8'h7F)
      $display("FAIL collision: got st=%h y=%h want 42 7f", so[0], yo[0]);
    else n_pass++;
    for (int i = 1; i < 3; i++) begin
      n_checks++;
      if (so[i] !== exp_status(i)) $display("FAIL collision dut%0d: got st=%h want %h", i, so[i], exp_status(i));
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    step_x(1);
    repeat (SS + 2) @(negedge clk);
    pulse_clear();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (xo[i] !== 8'(mx[i]) || yo[i] !== 8'(my[i]) || so[i] !== exp_status(i))
        $display("FAIL async_reset dut%0d: got x=%h y=%h st=%h want x=%h y=%h st=%h",
                 i, xo[i], yo[i], so[i], 8'(mx[i]), 8'(my[i]), exp_status(i));
      else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_random();
    int op;
    do_reset(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 9);
      if (op < 7) set_pins(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b1);
      else if (op < 9) pulse_clear();
      repeat (SS + 2 + $urandom_range(0, 3)) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (xo[i] !== 8'(mx[i]) || yo[i] !== 8'(my[i]) || so[i] !== exp_status(i))
          $display("FAIL random n%0d dut%0d: got x=%h y=%h st=%h want x=%h y=%h st=%h",
                   n, i, xo[i], yo[i], so[i], 8'(mx[i]), 8'(my[i]), exp_status(i));
        else n_pass++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_forward();
    test_saturate();
    test_illegal_clear();
    test_hold();
    test_clear_collision();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pos_tracker.md
# pos_tracker

Quadrature position tracker that supplies the `x_pos`, `y_pos` and `status` bytes read out by the I2C slave. It decodes two incremental quadrature inputs (X and Y axes) into 8-bit positions and keeps sticky motion/error flags. It presents a snapshot that can be frozen, so a multi-byte bus read sees a coherent triple. It sits directly upstream of the I2C slave, and its three output bytes wire straight to that block's data inputs.

## Interface
- `SATURATE`, default 1: 1 = clamp at 0/255; 0 = wrap modulo 256.
- `X_INIT`, default 8'd128: X position after reset.
- `Y_INIT`, default 8'd128: Y position after reset.
- `SYNC_STAGES`, default 2 (legal values 2–4): synchronizer depth on every quadrature pin.
- `clk` input 1: single clock for all logic.
- `rst_n` input 1: asynchronous, active-low reset.
- `x_a`, `x_b` input 1 each: X quadrature phases (asynchronous).
- `y_a`, `y_b` input 1 each: Y quadrature phases (asynchronous).
- `hold` input 1: 1 = freeze output snapshot; live tracking continues.
- `clear` input 1: one-cycle pulse that clears the sticky flags (status[3:0]) and increments the read counter.
- `x_pos` output 8: snapshot X position; reset value `X_INIT`.
- `y_pos` output 8: snapshot Y position; reset value `Y_INIT`.
- `status` output 8: snapshot status byte; reset value {2'b00, Y_INIT∈{0,255}, X_INIT∈{0,255}, 4'b0}, which is 8'h00 at the defaults.

## Operation
- **Synchronizer:** each pin passes through `SYNC_STAGES` flops, all reset to 0.
- **Per-axis decoder:** a 4-state Gray FSM with states S00, S01, S11, S10 (the state is the last accepted {a,b}).
  - Forward sequence S00→S01→S11→S10→S00 gives step INC.
  - Reverse sequence gives step DEC.
  - No change gives NONE.
  - Both bits changing gives ERR: the state is updated to the new {a,b}, the position is unchanged, and the error flag is set.
- **Priming:** after reset, a per-axis counter waits `SYNC_STAGES` cycles. The first valid synchronized sample is then loaded as the FSM state without decoding, so no spurious step or error is produced whatever the idle pin levels are.
- **Position arithmetic:** 8-bit unsigned.
  - INC at 255: stays 255 if `SATURATE`=1, otherwise becomes 0.
  - DEC at 0: stays 0 if `SATURATE`=1, otherwise becomes 255.
- **Live status byte:**
  - bit0 X moved (sticky; set on any INC/DEC, including a saturated no-op).
  - bit1 Y moved (sticky).
  - bit2 X error (sticky).
  - bit3 Y error (sticky).
  - bit4 X at limit (live, x==0 or x==255).
  - bit5 Y at limit (live).
  - bits7:6 read counter, incremented on each `clear` and wrapping 3→0.
- **`clear`:**
  - Clears bits3:0 of the live status.
  - A set event in the same cycle wins, so that flag reads 1 afterwards.
  - Acts regardless of `hold`.
- **Snapshot:**
  - When `hold`=0, the output registers load the live position and status every cycle.
  - When `hold`=1, the outputs keep their values.
  - On release, the outputs take the live values one edge later.
- **Reset mid-operation:** everything returns to reset values immediately (asynchronously), and priming restarts.

## Timing
- **Pin to output latency:** a pin transition first sampled at edge k appears in the live position at edge k+`SYNC_STAGES`. It appears on `x_pos`/`y_pos` at edge k+`SYNC_STAGES`+1 (with `hold`=0).
- **Step rate:** at most one step per axis per cycle. Pin transitions must be at least `SYNC_STAGES`+1 cycles apart; faster inputs give an ERR or missed steps (by design, not recovered).
- **`clear`:** takes effect on the live flags at the next edge, and on the outputs one edge after that.
- **Axes:** X and Y are fully independent; simultaneous steps on both axes are both applied in the same cycle.

## Structure
- **Package `pos_pkg`:**
  - step enum {STEP_NONE, STEP_INC, STEP_DEC, STEP_ERR}.
  - Gray state enum {S00, S01, S11, S10}.
  - Status bit index constants (ST_XMOV=0, ST_YMOV=1, ST_XERR=2, ST_YERR=3, ST_XLIM=4, ST_YLIM=5, ST_RCNT=7:6).
- **Sub-module `quad_decoder`** (instantiated twice): contains the synchronizer, priming counter and Gray FSM, and outputs a `pos_pkg` step each cycle.
- **Top level:** position arithmetic, sticky flags, read counter and snapshot registers.

## Test plan
- **Reset with idle pins:** pins held at 11 through reset; run 20 cycles → x_pos=y_pos=0x80, status=0x00, no error bits.
- **Forward steps:** 5 forward X steps (00→01→11→10→00→01) spaced 4 cycles → x_pos=0x85, status=0x01; each step reaches the output exactly `SYNC_STAGES`+1 edges after sampling.
- **Saturation and wrap:** X_INIT=254, 3 INC steps with `SATURATE`=1 → x_pos=0xFF, status bit4=1; same stimulus with `SATURATE`=0 → x_pos=0x01, bit4=0.
- **Illegal transition then clear:** Y pins jump 00→11 → status=0x08, y_pos unchanged; pulse `clear` → status=0x40.
- **Hold:** raise `hold`, apply 3 X DEC steps → x_pos frozen at 0x80 while the live value is 0x7D; drop `hold` → x_pos=0x7D on the next edge.
- **Clear collision:** `clear` and a Y step land in the same cycle → bit1 remains 1 and the read counter increments.
